// File: rtl/conv1_seq.sv
// conv1_seq: steps one shared conv1 channel-group datapath through all output channels.
// Define CONV1_SEQ_PERF_EN to add the stall_cnt output (WRITE cycles stalled by out_ready).
module conv1_seq #(
    parameter int bW         = 8,
    parameter int N_OCH      = 18,
    parameter int N_ICH      = 5,
    parameter int SETTLE_CYC = 2,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wmem_rd,
    output logic [ADDR_W-1:0] wmem_addr,
    input  logic [24:0]       wmem_rdata,
    output logic              dp_kernel_we,
    output logic [2:0]        dp_kernel_idx,
    output logic [24:0]       dp_kernel_bits,
    output logic              dp_offset_we,
    output logic [bW-1:0]     dp_offset,
    output logic              out_wr,
    output logic [4:0]        out_chan,
    input  logic              out_ready
`ifdef CONV1_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [2:0]      K_LAST   = 3'(N_ICH);
    localparam logic [4:0]      G_LAST   = 5'(N_OCH - 1);
    localparam logic [ST_W-1:0] SET_LAST = ST_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN  = 3'd2,
        S_SETTLE = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    logic [4:0]        r_g;
    logic [2:0]        r_k;
    logic [ST_W-1:0]   r_settle;
    logic              r_busy, r_done, r_wmem_rd, r_kernel_we, r_offset_we, r_out_wr;
    logic [ADDR_W-1:0] r_wmem_addr;
    logic [2:0]        r_kernel_idx;
    logic [4:0]        r_out_chan;

    state_t            w_state_nx;
    logic [4:0]        w_g_nx;
    logic [2:0]        w_k_nx;
    logic [ST_W-1:0]   w_settle_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic              w_kernel_ld, w_offset_ld;

    // Next-state and counter update; abort overrides every state.
    always_comb begin
        w_state_nx  = r_state;
        w_g_nx      = r_g;
        w_k_nx      = r_k;
        w_settle_nx = r_settle;
        if (abort) begin
            w_state_nx  = S_IDLE;
            w_g_nx      = 5'd0;
            w_k_nx      = 3'd0;
            w_settle_nx = {ST_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_g_nx      = 5'd0;
                    w_k_nx      = 3'd0;
                    w_settle_nx = {ST_W{1'b0}};
                    if (start) begin
                        w_state_nx = S_FETCH;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (r_k == K_LAST) begin
                        w_state_nx = S_DRAIN;
                    end else begin
                        w_k_nx = r_k + 3'd1;
                    end
                end
                S_DRAIN: begin
                    w_state_nx  = S_SETTLE;
                    w_settle_nx = {ST_W{1'b0}};
                end
                S_SETTLE: begin
                    if (r_settle == SET_LAST) begin
                        w_state_nx = S_WRITE;
                    end else begin
                        w_settle_nx = r_settle + ST_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!out_ready) begin
                        w_state_nx = S_WRITE;
                    end else if (r_g == G_LAST) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_FETCH;
                        w_g_nx     = r_g + 5'd1;
                        w_k_nx     = 3'd0;
                    end
                end
                S_DONE: begin
                    w_state_nx  = S_IDLE;
                    w_g_nx      = 5'd0;
                    w_k_nx      = 3'd0;
                    w_settle_nx = {ST_W{1'b0}};
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Read address for the coming FETCH cycle and the load that follows the current read.
    always_comb begin
        w_addr_nx   = {ADDR_W{1'b0}};
        w_kernel_ld = 1'b0;
        w_offset_ld = 1'b0;
        if (w_state_nx == S_FETCH) begin
            if (w_k_nx < K_LAST) begin
                w_addr_nx = ADDR_W'(32'(w_g_nx) * N_ICH + 32'(w_k_nx));
            end else begin
                w_addr_nx = ADDR_W'(N_OCH * N_ICH + 32'(w_g_nx));
            end
        end else begin
            w_addr_nx = {ADDR_W{1'b0}};
        end
        if (!abort && r_state == S_FETCH) begin
            w_kernel_ld = (r_k < K_LAST);
            w_offset_ld = (r_k == K_LAST);
        end else begin
            w_kernel_ld = 1'b0;
            w_offset_ld = 1'b0;
        end
    end

    // State, counters and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_g          <= 5'd0;
            r_k          <= 3'd0;
            r_settle     <= {ST_W{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wmem_rd    <= 1'b0;
            r_wmem_addr  <= {ADDR_W{1'b0}};
            r_kernel_we  <= 1'b0;
            r_kernel_idx <= 3'd0;
            r_offset_we  <= 1'b0;
            r_out_wr     <= 1'b0;
            r_out_chan   <= 5'd0;
        end else begin
            r_state      <= w_state_nx;
            r_g          <= w_g_nx;
            r_k          <= w_k_nx;
            r_settle     <= w_settle_nx;
            r_busy       <= (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
            r_done       <= (w_state_nx == S_DONE);
            r_wmem_rd    <= (w_state_nx == S_FETCH);
            r_wmem_addr  <= w_addr_nx;
            r_kernel_we  <= w_kernel_ld;
            r_kernel_idx <= w_kernel_ld ? r_k : 3'd0;
            r_offset_we  <= w_offset_ld;
            r_out_wr     <= (w_state_nx == S_WRITE);
            r_out_chan   <= (w_state_nx == S_WRITE) ? w_g_nx : 5'd0;
        end
    end

    // Load data comes straight from memory in the cycle after the read, gated by the strobe.
    assign dp_kernel_bits = r_kernel_we ? wmem_rdata : 25'd0;
    assign dp_offset      = r_offset_we ? wmem_rdata[bW-1:0] : {bW{1'b0}};
    assign busy           = r_busy;
    assign done           = r_done;
    assign wmem_rd        = r_wmem_rd;
    assign wmem_addr      = r_wmem_addr;
    assign dp_kernel_we   = r_kernel_we;
    assign dp_kernel_idx  = r_kernel_idx;
    assign dp_offset_we   = r_offset_we;
    assign out_wr         = r_out_wr;
    assign out_chan       = r_out_chan;

`ifdef CONV1_SEQ_PERF_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled WRITE cycles, cleared when a new pass is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (r_state == S_IDLE && start && !abort) begin
            r_stall_cnt <= 16'd0;
        end else if (r_state == S_WRITE && !out_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv1_seq.sv
// Self-checking bench for conv1_seq: scenario table plus abort and mid-pass reset sequences.
module tb_conv1_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, wmem_rd, dp_kernel_we, dp_offset_we, out_wr;
    logic [6:0]  wmem_addr;
    logic [24:0] wmem_rdata;
    logic [2:0]  dp_kernel_idx;
    logic [24:0] dp_kernel_bits;
    logic [7:0]  dp_offset;
    logic [4:0]  out_chan;
`ifdef CONV1_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [24:0] mem [0:127];

    // model of the expected read/load stream
    int          rd_idx = 0;
    bit          prev_rd = 1'b0;
    logic [6:0]  prev_addr = 7'd0;

    typedef struct {
        int stall_chan;
        int stall_len;
        int start_at;
        int exp_done;
        int exp_writes;
    } vec_t;
    vec_t vecs [0:7];

    conv1_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .wmem_rd(wmem_rd), .wmem_addr(wmem_addr),
        .wmem_rdata(wmem_rdata), .dp_kernel_we(dp_kernel_we), .dp_kernel_idx(dp_kernel_idx),
        .dp_kernel_bits(dp_kernel_bits), .dp_offset_we(dp_offset_we), .dp_offset(dp_offset),
        .out_wr(out_wr), .out_chan(out_chan), .out_ready(out_ready)
`ifdef CONV1_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // one-cycle read latency; garbage on the bus when no read is pending
    always @(posedge clk) wmem_rdata <= wmem_rd ? mem[wmem_addr] : 25'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int grp, j, exp_addr;
        bit exp_k, exp_o;
        if (!rst_n) begin
            prev_rd = 1'b0;
            return;
        end
        exp_k = prev_rd && !abort && (prev_addr < 7'd90);
        exp_o = prev_rd && !abort && (prev_addr >= 7'd90);
        chk("kernel_we", {31'd0, dp_kernel_we}, {31'd0, exp_k});
        chk("offset_we", {31'd0, dp_offset_we}, {31'd0, exp_o});
        if (exp_k) begin
            chk("kernel_idx", {29'd0, dp_kernel_idx}, prev_addr % 5);
            chk("kernel_bits", {7'd0, dp_kernel_bits}, {7'd0, mem[prev_addr]});
        end else begin
            chk("kernel_bits_idle", {7'd0, dp_kernel_bits}, 32'd0);
        end
        if (exp_o) begin
            chk("offset_val", {24'd0, dp_offset}, {24'd0, mem[prev_addr][7:0]});
        end else begin
            chk("offset_idle", {24'd0, dp_offset}, 32'd0);
        end
        if (wmem_rd) begin
            grp = rd_idx / 6;
            j = rd_idx % 6;
            exp_addr = (j < 5) ? grp * 5 + j : 90 + grp;
            chk("rd_addr", {25'd0, wmem_addr}, exp_addr);
            chk("rd_during_write", {31'd0, out_wr}, 32'd0);
            rd_idx++;
        end
        prev_rd = wmem_rd;
        prev_addr = wmem_addr;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_pass(input vec_t v);
        int t0, nwr, stalls, ndone, done_at;
        bit prev_wr;
        nwr = 0; stalls = 0; ndone = 0; done_at = 0; prev_wr = 1'b0;
        rd_idx = 0;
        out_ready = 1'b1;
        start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 400; n++) begin
            tick();
            start = (v.start_at != 0) && (cyc - t0 == v.start_at);
            if (n == 1) chk("busy_rise", {31'd0, busy}, 32'd1);
            if (out_wr) begin
                chk("out_chan", {27'd0, out_chan}, nwr);
                if (!prev_wr) chk("write_time", cyc - t0, 10 * (nwr + 1) + stalls);
                if (nwr == v.stall_chan && stalls < v.stall_len) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    nwr++;
                end
            end else begin
                out_ready = 1'b1;
            end
            prev_wr = out_wr;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    done_at = cyc;
                    chk("done_time", cyc - t0, v.exp_done);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
            if (ndone > 0 && cyc - done_at >= 6) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("writes", nwr, v.exp_writes);
        chk("done_pulses", ndone, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
`ifdef CONV1_SEQ_PERF_EN
        chk("stall_cnt", {16'd0, stall_cnt}, v.stall_len);
`endif
    endtask

    task automatic run_abort();
        int t0, nwr, nd;
        nwr = 0; nd = 0;
        rd_idx = 0;
        out_ready = 1'b1;
        start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 98; n++) begin
            tick();
            start = 1'b0;
            if (out_wr) begin
                chk("abort_chan", {27'd0, out_chan}, nwr);
                nwr++;
            end
        end
        // cycle T+98 is the first SETTLE cycle of group 9
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wr", {31'd0, out_wr}, 32'd0);
        chk("abort_rd", {31'd0, wmem_rd}, 32'd0);
        chk("abort_writes", nwr, 32'd9);
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_over_start", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_over_start_rd", {31'd0, wmem_rd}, 32'd0);
    endtask

    task automatic run_reset_mid();
        rd_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", {31'd0, wmem_rd}, 32'd0);
        chk("rst_addr", {25'd0, wmem_addr}, 32'd0);
        chk("rst_kwe", {31'd0, dp_kernel_we}, 32'd0);
        chk("rst_owe", {31'd0, dp_offset_we}, 32'd0);
        chk("rst_wr", {31'd0, out_wr}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_release_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 25'($urandom);
        vecs[0] = '{0, 0, 0, 181, 18};
        vecs[1] = '{5, 7, 0, 188, 18};
        vecs[2] = '{3, 2, 50, 183, 18};
        vecs[3] = '{17, 1, 182, 182, 18};
        vecs[4] = '{0, 4, 0, 185, 18};
        for (int i = 5; i < 8; i++) begin
            vecs[i].stall_chan = int'($urandom_range(0, 17));
            vecs[i].stall_len  = int'($urandom_range(0, 6));
            vecs[i].start_at   = int'($urandom_range(20, 170));
            vecs[i].exp_done   = 181 + vecs[i].stall_len;
            vecs[i].exp_writes = 18;
        end

        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rd", {31'd0, wmem_rd}, 32'd0);
        chk("reset_addr", {25'd0, wmem_addr}, 32'd0);
        chk("reset_kwe", {31'd0, dp_kernel_we}, 32'd0);
        chk("reset_kidx", {29'd0, dp_kernel_idx}, 32'd0);
        chk("reset_owe", {31'd0, dp_offset_we}, 32'd0);
        chk("reset_wr", {31'd0, out_wr}, 32'd0);
        chk("reset_chan", {27'd0, out_chan}, 32'd0);
`ifdef CONV1_SEQ_PERF_EN
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_pass(vecs[i]);
        run_abort();
        run_pass(vecs[0]);
        run_reset_mid();
        run_pass(vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
